// File: rtl/counter_arbiter.sv
// counter_arbiter
//   Shares a single count-to-limit timer between NUM_REQ requesters using
//   round-robin arbitration. The winner's limit is latched and a one-cycle
//   start_count is issued. The counter's counting flag is then followed
//   through one full run, and done is pulsed to the owner when the run ends.
//   If counting never rises after start, the operation is abandoned and err
//   is pulsed.
//
// Ports
//   clk          system clock, all logic on posedge
//   reset        synchronous, active-high reset
//   req          per-requester request, held until done/err
//   limit_in     packed limits, requester i uses [i*WIDTH +: WIDTH]
//   counting     counter's counting flag
//   start_count  one-cycle start strobe to the counter
//   limit        latched limit to the counter (registered)
//   grant        one-hot owner of the counter
//   done         one-cycle pulse to the owner at run completion
//   err          one-cycle pulse on start timeout
//   busy         high whenever the arbiter is not idle
module counter_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int WIDTH         = 17,
    parameter int START_TIMEOUT = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] limit_in,
    input  logic                     counting,
    output logic                     start_count,
    output logic [WIDTH-1:0]         limit,
    output logic [NUM_REQ-1:0]       grant,
    output logic [NUM_REQ-1:0]       done,
    output logic                     err,
    output logic                     busy
);

    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int TW = $clog2(START_TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_WAIT_HI,
        S_RUN,
        S_DONE
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [PW-1:0]        r_ptr;
    logic [PW-1:0]        r_owner;
    logic [TW-1:0]        r_tmo;
    logic [NUM_REQ-1:0]   r_grant;
    logic [WIDTH-1:0]     r_limit;
    logic                 r_err;

    logic                 w_found;
    logic [PW-1:0]        w_win;
    logic [WIDTH-1:0]     w_lim_sel;
    int                   w_idx;
    logic [PW-1:0]        w_sel;
    logic                 w_grant_ev;
    logic                 w_tmo_ev;

    // Round-robin search starting just after the last owner, with wrap.
    always_comb begin
        w_found   = 1'b0;
        w_win     = '0;
        w_lim_sel = '0;
        w_idx     = 0;
        w_sel     = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idx = (int'(r_ptr) + 1 + i) % NUM_REQ;
            w_sel = PW'(w_idx);
            if (!w_found && req[w_sel]) begin
                w_found   = 1'b1;
                w_win     = w_sel;
                w_lim_sel = limit_in[w_idx*WIDTH +: WIDTH];
            end
        end
    end

    // Next-state logic. The counter has no reset, so it may still be running
    // after an arbiter reset; IDLE holds off granting until it goes quiet.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (!counting && w_found) w_state_nxt = S_START;
            S_START:   w_state_nxt = S_WAIT_HI;
            S_WAIT_HI: begin
                if (counting)
                    w_state_nxt = S_RUN;
                else if (r_tmo == TW'(START_TIMEOUT))
                    w_state_nxt = S_IDLE;
            end
            S_RUN:     if (!counting) w_state_nxt = S_DONE;
            S_DONE:    w_state_nxt = S_IDLE;
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    assign w_grant_ev = (r_state == S_IDLE) && (w_state_nxt == S_START);
    assign w_tmo_ev   = (r_state == S_WAIT_HI) && (w_state_nxt == S_IDLE);

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_grant <= '0;
            r_limit <= '0;
            r_ptr   <= PW'(NUM_REQ - 1);
            r_owner <= '0;
            r_tmo   <= '0;
            r_err   <= 1'b0;
        end else begin
            r_err <= w_tmo_ev;
            case (r_state)
                S_IDLE: begin
                    if (w_grant_ev) begin
                        r_grant <= NUM_REQ'(1) << w_win;
                        r_limit <= w_lim_sel;
                        r_owner <= w_win;
                    end
                end
                S_START: r_tmo <= '0;
                S_WAIT_HI: begin
                    if (w_tmo_ev) begin
                        r_grant <= '0;
                        r_ptr   <= r_owner;
                    end else if (!counting) begin
                        r_tmo <= r_tmo + 1'b1;
                    end
                end
                S_DONE: begin
                    r_grant <= '0;
                    r_ptr   <= r_owner;
                end
                default: ;
            endcase
        end
    end

    assign start_count = (r_state == S_START);
    assign done        = (r_state == S_DONE) ? r_grant : '0;
    assign busy        = (r_state != S_IDLE);
    assign grant       = r_grant;
    assign limit       = r_limit;
    assign err         = r_err;

endmodule

// File: doc/counter_arbiter.md
Name: counter_arbiter

Overview:
- Shares one `counter` instance (17-bit count-to-limit timer) between NUM_REQ requesters; round-robin fairness.
- Latches the winner's limit, issues a one-cycle `start_count`, and tracks the counter's `counting` flag through one full run.
- Pulses a per-requester `done` when the run ends.
- Includes a start watchdog: if the counter never responds, the operation is abandoned and `err` is pulsed.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- WIDTH, 17, limit width; matches the counter's limit/result width.
- START_TIMEOUT, 3, cycles allowed in WAIT_HI for `counting` to rise.

Ports:
- clk  input  1  system clock, all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- req  input  NUM_REQ  per-requester request; held high until that requester's done/err.
- limit_in  input  NUM_REQ*WIDTH  packed limits; requester i uses bits [i*WIDTH +: WIDTH].
- counting  input  1  from counter `counting`.
- start_count  output  1  to counter `start_count`.
- limit  output  WIDTH  to counter `limit`; registered.
- grant  output  NUM_REQ  one-hot; current owner of the counter.
- done  output  NUM_REQ  one-cycle pulse to the owner at run completion.
- err  output  1  one-cycle pulse on start timeout.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset is synchronous, active-high, and one clock is used.
  - On reset: state=IDLE; grant, done, err, limit = 0; start_count=0; busy=0; timeout count=0; rr pointer=NUM_REQ-1, so requester 0 has first priority.
- States: IDLE, START, WAIT_HI, RUN, DONE.
- IDLE: grant only when counting==0 and req!=0.
  - If counting==1 (e.g. the counter ran on across an arbiter reset, since the counter has no reset), wait in IDLE.
- Winner selection: first requester with req high, searching (ptr+1) mod NUM_REQ upward with wrap.
  - On the grant edge: grant<=onehot(winner), limit<=limit_in slice, state<=START.
- START: start_count=1 (decoded from state, exactly one cycle); next state WAIT_HI; timeout count cleared.
- WAIT_HI: if counting==1, go to RUN.
  - Else increment the timeout count.
  - When the count reaches START_TIMEOUT: err pulse next cycle, grant cleared, ptr<=winner, state<=IDLE, no done.
- RUN: remain while counting==1; on counting==0, go to DONE.
- DONE: done[winner]=1 for one cycle; grant<=0, ptr<=winner; next state IDLE.
  - The next grant occurs at the earliest on the edge after DONE.
- Stability: limit and grant are held constant from the grant edge through DONE.
- Input sampling during an operation:
  - limit_in changes during an operation are ignored.
  - A req drop by the owner mid-operation is ignored; the run completes and done still pulses (the counter cannot be aborted).
- Latency for limit L, with grant edge = edge 1:
  - start_count high in cycle 1–2.
  - counter counting=1 after edge 2; RUN entered at edge 3.
  - counting falls after edge 3+L.
  - DONE entered at edge 4+L; done visible in cycle 4+L..5+L.
  - L=0 obeys the same formula.
- Simultaneous events: multiple req rising the same cycle are resolved by the rr pointer only; no fixed priority beyond the reset pointer value.
- Reset mid-operation: all outputs drop the following cycle, and no done/err is emitted for the aborted owner.

Test Plan:
- Single request: req=4'b0001, limit_in[0]=5, real counter attached → grant=0001 after edge 1; one-cycle start_count; limit=5; done[0] pulses at cycle 9; busy low after.
- Round-robin: req=4'b1111 held, limits 2/3/4/5 → grant order 0,1,2,3,0; each done only to its owner; no back-to-back grant without an intervening IDLE cycle.
- Limit 0 and max: limit_in[2]=0 → done[2] at cycle 4. Limit 17'h1FFFF with a shortened bench → no wrap issues; limit stable through RUN.
- Timeout: counting tied 0, req=0010 → err pulses once, START_TIMEOUT+2 cycles after the grant edge; done stays 0; the next request goes to requester 2 first.
- Reset mid-RUN: assert reset during RUN with counting still 1 → outputs zero next cycle; with req pending, no grant until counting==0; then requester 0 is granted.
- Owner drops req mid-RUN → run completes, done pulses; the pointer advances normally.
